// File: rtl/issue_controller_pkg.sv
// Shared types and helpers for the decode-to-execute issue controller.
package issue_controller_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ISSUE_RUN    = 2'd0,
    ISSUE_DRAIN  = 2'd1,
    ISSUE_SERIAL = 2'd2
  } issue_state_t;

  // Register index 0 is hard-wired zero and therefore never a real dependency.
  function automatic logic reg_hit(input logic [REG_IDX_W-1:0] i_src,
                                   input logic [REG_IDX_W-1:0] i_dst);
    return (i_dst != '0) && (i_src == i_dst);
  endfunction

endpackage

// File: rtl/issue_controller_pipe_tracker.sv
// Per-stage valid shift register for issued instructions, plus the destination
// and load flag of whatever currently sits in EX.
module issue_controller_pipe_tracker
  import issue_controller_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_advance,
  input  logic                 i_issue,
  input  logic                 i_load,
  input  logic [REG_IDX_W-1:0] i_rd,
  output logic                 o_ex_valid,
  output logic [REG_IDX_W-1:0] o_ex_rd,
  output logic                 o_ex_load,
  output logic                 o_empty
);

  logic [DEPTH-1:0]     r_occ;
  logic [REG_IDX_W-1:0] r_ex_rd;
  logic                 r_ex_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ     <= '0;
      r_ex_rd   <= '0;
      r_ex_load <= 1'b0;
    end else if (i_advance) begin
      r_occ     <= {r_occ[DEPTH-2:0], i_issue};
      r_ex_rd   <= i_rd;
      r_ex_load <= i_load;
    end
  end

  // The WB-stage instruction retires on the advancing edge, so the pipe counts as
  // empty once nothing is left below it; an atomic may enter EX on that same edge.
  assign o_empty    = (r_occ[DEPTH-2:0] == '0);
  assign o_ex_valid = r_occ[0];
  assign o_ex_rd    = r_ex_rd;
  assign o_ex_load  = r_ex_load;

endmodule

// File: rtl/issue_controller.sv
// Decides each cycle whether the ID instruction issues, stalls or is flushed:
// load-use interlock, full serialisation of atomics, redirect flushes.
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic                 i_atomic,
  input  logic                 i_ma_res_sel,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_ex_redirect,
  input  logic                 i_ma_stall,
  output logic                 o_issue,
  output logic                 o_id_stall,
  output logic                 o_flush,
  output logic                 o_busy
);

  issue_state_t         r_state;
  issue_state_t         w_state_next;
  logic                 w_advance;
  logic                 w_ex_valid;
  logic [REG_IDX_W-1:0] w_ex_rd;
  logic                 w_ex_load;
  logic                 w_empty;
  logic                 w_hazard;
  logic                 w_permit;
  logic                 w_issue;

  assign w_advance = !i_ma_stall;

  issue_controller_pipe_tracker #(
    .DEPTH (DEPTH)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_advance  (w_advance),
    .i_issue    (w_issue),
    .i_load     (w_issue & i_ma_res_sel),
    .i_rd       (i_rd),
    .o_ex_valid (w_ex_valid),
    .o_ex_rd    (w_ex_rd),
    .o_ex_load  (w_ex_load),
    .o_empty    (w_empty)
  );

  assign w_hazard = w_ex_valid & w_ex_load &
                    (reg_hit(i_rs1, w_ex_rd) | reg_hit(i_rs2, w_ex_rd));

  assign w_permit = (r_state == ISSUE_RUN)   ? (i_atomic ? w_empty : !w_hazard) :
                    (r_state == ISSUE_DRAIN) ? w_empty : 1'b0;

  // Reset gates issue so nothing is reported as entering EX while held in reset.
  assign w_issue = i_rst_n & i_id_valid & w_permit & !i_ma_stall & !i_ex_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ISSUE_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ISSUE_RUN: begin
        if (i_id_valid && i_atomic && !i_ex_redirect) begin
          if (!w_empty) begin
            w_state_next = ISSUE_DRAIN;
          end else if (w_issue) begin
            w_state_next = ISSUE_SERIAL;
          end
        end
      end
      ISSUE_DRAIN: begin
        if (i_ex_redirect) begin
          w_state_next = ISSUE_RUN;
        end else if (w_issue) begin
          w_state_next = ISSUE_SERIAL;
        end
      end
      ISSUE_SERIAL: begin
        if (w_empty && !i_ma_stall) begin
          w_state_next = ISSUE_RUN;
        end
      end
      default: begin
        w_state_next = ISSUE_RUN;
      end
    endcase
  end

  assign o_issue    = w_issue;
  assign o_flush    = i_ex_redirect;
  assign o_id_stall = i_id_valid & !w_issue & !i_ex_redirect;
  assign o_busy     = (r_state != ISSUE_RUN);

endmodule
